cursor_move_ctrl: RTL and testbench
===================================

# cursor_move_ctrl

Grid-snapped cursor controller for the minesweeper board. It converts the four direction buttons into single-tile cursor moves, with hold-to-auto-repeat. It outputs the cursor's board cell (col, row) and that tile's top-left pixel origin (xpos, ypos). The VGA sprite path and the game logic both read these outputs; this block owns the only copy of cursor position in the design.

## Interface
Parameters:
- COLS, 16, board width in tiles (2..32)
- ROWS, 16, board height in tiles (2..32)
- TILE, 30, tile pitch in pixels
- X0, 144, hCount of the first visible column
- Y0, 35, vCount of the first visible row
- START_COL, 7, column after reset
- START_ROW, 7, row after reset
- REPEAT_DELAY, 20, ticks from the first move to the first repeat (≥1)
- REPEAT_RATE, 6, ticks between repeats (≥1)

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-cycle frame strobe (one per vsync); all sampling and moves happen only on tick cycles
- up, down, left, right  in  1 each  debounced, clk-synchronous button levels
- col  out  5  cursor column, 0..COLS-1
- row  out  5  cursor row, 0..ROWS-1
- xpos  out  10  X0 + col*TILE
- ypos  out  10  Y0 + row*TILE
- moved  out  1  one-cycle pulse in the cycle a new position first appears

## Operation
- Direction decode uses fixed priority: right > left > up > down. Only the winning direction acts on a given tick.
- Up decrements row and down increments it. Left decrements col and right increments it.
- FSM states: IDLE, DELAY, REPEAT. A tick counter is cleared on every state change.
  - IDLE: on a tick with any direction asserted, move once, latch the direction, and go to DELAY.
  - DELAY: on each tick, increment the counter. When the counter reaches REPEAT_DELAY, move and go to REPEAT.
  - REPEAT: on each tick, increment the counter. Every REPEAT_RATE ticks, move.
  - In DELAY or REPEAT, if the winning direction on a tick differs from the latched one (this includes a different button winning), treat it as a new press: move in the new direction on that tick, latch it, and go to DELAY.
  - In DELAY or REPEAT, if no button is asserted on a tick, go to IDLE with no move.
- xpos and ypos are maintained incrementally (add or subtract TILE alongside col/row changes). No multiplier is used. Wrap loads the X0/Y0 or far-edge constant directly.
- Edge behaviour depends on CURSOR_WRAP_EN (see Configuration).
- Button changes between ticks are ignored.

## Timing
- Reset values: col=START_COL, row=START_ROW, xpos=X0+START_COL*TILE, ypos=Y0+START_ROW*TILE, moved=0, state IDLE, counter 0.
- All outputs are registered.
- Latency: a move decided in tick cycle T updates col, row, xpos, ypos at the edge ending cycle T. moved=1 during cycle T+1 only.
- Move count for one direction held continuously from tick n: moves occur at ticks n, n+REPEAT_DELAY, then n+REPEAT_DELAY+k*REPEAT_RATE.
- rst takes priority over tick at any point, including mid-DELAY or mid-REPEAT. No moved pulse follows reset. A button still held after reset is released counts as a new press on the next tick.
- With tick held low, state, position and moved are frozen; moved is still 0 after its single pulse.

## Configuration
- CURSOR_WRAP_EN defined:
  - right at col=COLS-1 gives col=0, xpos=X0
  - left at col=0 gives col=COLS-1
  - the same applies to rows
  - a wrap counts as a move and pulses moved
- CURSOR_WRAP_EN undefined:
  - moves past an edge saturate: position unchanged, no moved pulse
  - the FSM still advances as if a move occurred, so repeat timing is unchanged

## Test plan
- Reset (default parameters) → col=7, row=7, xpos=354, ypos=245, moved=0.
- Right held for exactly 1 tick, then released → col=8, xpos=384, exactly one moved pulse, FSM back in IDLE on the next tick.
- Right held for 40 consecutive ticks from reset → moves at ticks 0, 20, 26, 32, 38; final col=12, xpos=504; 5 moved pulses.
- Set col=15, press right:
  - with CURSOR_WRAP_EN → col=0, xpos=144, moved=1
  - without it → col=15, xpos=594, moved=0
- Right and up held together for 1 tick → col=8, row=7. Then right released and up kept held → row=6, ypos=215 on the very next tick (new press, no delay).
- Right held 25 ticks (FSM in REPEAT), rst pulsed for 1 cycle with right still held → reset values next cycle, no moved pulse; on the next tick col=8 (fresh press).

Source files
------------

// File: rtl/cursor_move_ctrl.sv
// Grid-snapped cursor controller: direction buttons -> single-tile moves with hold-to-auto-repeat.
// Build option: define CURSOR_WRAP_EN to wrap at board edges instead of saturating.
module cursor_move_ctrl #(
  parameter int COLS         = 16,
  parameter int ROWS         = 16,
  parameter int TILE         = 30,
  parameter int X0           = 144,
  parameter int Y0           = 35,
  parameter int START_COL    = 7,
  parameter int START_ROW    = 7,
  parameter int REPEAT_DELAY = 20,
  parameter int REPEAT_RATE  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  output logic [4:0] col,
  output logic [4:0] row,
  output logic [9:0] xpos,
  output logic [9:0] ypos,
  output logic       moved
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

`ifdef CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  localparam int CMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [4:0] COL_LAST  = 5'(COLS - 1);
  localparam logic [4:0] ROW_LAST  = 5'(ROWS - 1);
  localparam logic [4:0] COL_START = 5'(START_COL);
  localparam logic [4:0] ROW_START = 5'(START_ROW);
  localparam logic [9:0] STEP      = 10'(TILE);
  localparam logic [9:0] X_FIRST   = 10'(X0);
  localparam logic [9:0] Y_FIRST   = 10'(Y0);
  localparam logic [9:0] X_LAST    = 10'(X0 + (COLS - 1) * TILE);
  localparam logic [9:0] Y_LAST    = 10'(Y0 + (ROWS - 1) * TILE);
  localparam logic [9:0] X_START   = 10'(X0 + START_COL * TILE);
  localparam logic [9:0] Y_START   = 10'(Y0 + START_ROW * TILE);

  logic [1:0]    state, state_n;
  logic [1:0]    dir, dir_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [1:0]    win;
  logic          any;
  logic          do_move;
  logic          step;
  logic [4:0]    col_n, row_n;
  logic [9:0]    xpos_n, ypos_n;

  // Fixed priority: right > left > up > down.
  always_comb begin
    any = right | left | up | down;
    win = DIR_DOWN;
    if (right)     win = DIR_RIGHT;
    else if (left) win = DIR_LEFT;
    else if (up)   win = DIR_UP;
  end

  assign cnt_inc = cnt + CW'(1);

  always_comb begin
    state_n = state;
    dir_n   = dir;
    cnt_n   = cnt;
    do_move = 1'b0;
    if (tick) begin
      case (state)
        ST_IDLE: begin
          if (any) begin
            do_move = 1'b1;
            dir_n   = win;
            state_n = ST_DELAY;
            cnt_n   = '0;
          end
        end
        default: begin
          if (!any) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
          end else if (win != dir) begin
            do_move = 1'b1;
            dir_n   = win;
            state_n = ST_DELAY;
            cnt_n   = '0;
          end else if (state == ST_DELAY) begin
            if (cnt_inc == CW'(REPEAT_DELAY)) begin
              do_move = 1'b1;
              state_n = ST_REPEAT;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            if (cnt_inc == CW'(REPEAT_RATE)) begin
              do_move = 1'b1;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt_inc;
            end
          end
        end
      endcase
    end
  end

  // Pixel origin tracks col/row by +/-TILE; an edge without wrap leaves the FSM advancing
  // but suppresses the position change and the moved pulse.
  always_comb begin
    col_n  = col;
    row_n  = row;
    xpos_n = xpos;
    ypos_n = ypos;
    step   = 1'b0;
    if (do_move) begin
      case (dir_n)
        DIR_RIGHT: begin
          if (col != COL_LAST) begin
            col_n  = col + 5'd1;
            xpos_n = xpos + STEP;
            step   = 1'b1;
          end else if (WRAP) begin
            col_n  = '0;
            xpos_n = X_FIRST;
            step   = 1'b1;
          end
        end
        DIR_LEFT: begin
          if (col != 5'd0) begin
            col_n  = col - 5'd1;
            xpos_n = xpos - STEP;
            step   = 1'b1;
          end else if (WRAP) begin
            col_n  = COL_LAST;
            xpos_n = X_LAST;
            step   = 1'b1;
          end
        end
        DIR_UP: begin
          if (row != 5'd0) begin
            row_n  = row - 5'd1;
            ypos_n = ypos - STEP;
            step   = 1'b1;
          end else if (WRAP) begin
            row_n  = ROW_LAST;
            ypos_n = Y_LAST;
            step   = 1'b1;
          end
        end
        default: begin
          if (row != ROW_LAST) begin
            row_n  = row + 5'd1;
            ypos_n = ypos + STEP;
            step   = 1'b1;
          end else if (WRAP) begin
            row_n  = '0;
            ypos_n = Y_FIRST;
            step   = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      dir   <= DIR_RIGHT;
      cnt   <= '0;
      col   <= COL_START;
      row   <= ROW_START;
      xpos  <= X_START;
      ypos  <= Y_START;
      moved <= 1'b0;
    end else begin
      state <= state_n;
      dir   <= dir_n;
      cnt   <= cnt_n;
      col   <= col_n;
      row   <= row_n;
      xpos  <= xpos_n;
      ypos  <= ypos_n;
      moved <= step;
    end
  end

endmodule

// File: tb/tb_cursor_move_ctrl.sv
// Directed self-checking bench for cursor_move_ctrl (default parameters).
module tb_cursor_move_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic [4:0] col, row;
  logic [9:0] xpos, ypos;
  logic       moved;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cursor_move_ctrl #(
    .COLS(16), .ROWS(16), .TILE(30), .X0(144), .Y0(35),
    .START_COL(7), .START_ROW(7), .REPEAT_DELAY(20), .REPEAT_RATE(6)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .up(up), .down(down), .left(left), .right(right),
    .col(col), .row(row), .xpos(xpos), .ypos(ypos), .moved(moved)
  );

  // One tick with the given buttons; mv = moved in the following cycle, mv_gap = one cycle later.
  task automatic do_tick(input logic r, input logic l, input logic u, input logic d,
                         output logic mv, output logic mv_gap);
    @(negedge clk);
    right = r; left = l; up = u; down = d; tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0; right = 1'b0; left = 1'b0; up = 1'b0; down = 1'b0;
    mv = moved;
    @(posedge clk); #1;
    mv_gap = moved;
  endtask

  task automatic do_reset(input logic hold_right);
    @(negedge clk);
    rst = 1'b1; right = hold_right;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset(1'b0);
    vectors++; if (col !== 5'd7)    begin miscompares++; $display("FAIL reset_col: got %0d want 7", col); end
    vectors++; if (row !== 5'd7)    begin miscompares++; $display("FAIL reset_row: got %0d want 7", row); end
    vectors++; if (xpos !== 10'd354) begin miscompares++; $display("FAIL reset_xpos: got %0d want 354", xpos); end
    vectors++; if (ypos !== 10'd245) begin miscompares++; $display("FAIL reset_ypos: got %0d want 245", ypos); end
    vectors++; if (moved !== 1'b0)  begin miscompares++; $display("FAIL reset_moved: got %b want 0", moved); end
  endtask

  task automatic test_single_press;
    logic mv, mg;
    do_reset(1'b0);
    do_tick(1'b1, 1'b0, 1'b0, 1'b0, mv, mg);
    vectors++; if (col !== 5'd8)     begin miscompares++; $display("FAIL single_col: got %0d want 8", col); end
    vectors++; if (xpos !== 10'd384) begin miscompares++; $display("FAIL single_xpos: got %0d want 384", xpos); end
    vectors++; if (mv !== 1'b1)      begin miscompares++; $display("FAIL single_moved: got %b want 1", mv); end
    vectors++; if (mg !== 1'b0)      begin miscompares++; $display("FAIL single_moved_gap: got %b want 0", mg); end
    do_tick(1'b0, 1'b0, 1'b0, 1'b0, mv, mg);
    vectors++; if (mv !== 1'b0)      begin miscompares++; $display("FAIL release_moved: got %b want 0", mv); end
    vectors++; if (col !== 5'd8)     begin miscompares++; $display("FAIL release_col: got %0d want 8", col); end
    do_tick(1'b1, 1'b0, 1'b0, 1'b0, mv, mg);
    vectors++; if (col !== 5'd9)     begin miscompares++; $display("FAIL repress_col: got %0d want 9", col); end
    vectors++; if (mv !== 1'b1)      begin miscompares++; $display("FAIL repress_moved: got %b want 1", mv); end
  endtask

  task automatic test_hold_repeat;
    logic mv, mg, exp_mv;
    int pulses;
    pulses = 0;
    do_reset(1'b0);
    for (int i = 0; i < 40; i++) begin
      do_tick(1'b1, 1'b0, 1'b0, 1'b0, mv, mg);
      exp_mv = (i == 0 || i == 20 || i == 26 || i == 32 || i == 38);
      if (mv === 1'b1) pulses++;
      vectors++; if (mv !== exp_mv) begin miscompares++; $display("FAIL hold_moved_tick%0d: got %b want %b", i, mv, exp_mv); end
      vectors++; if (mg !== 1'b0)   begin miscompares++; $display("FAIL hold_gap_tick%0d: got %b want 0", i, mg); end
    end
    vectors++; if (pulses != 5)      begin miscompares++; $display("FAIL hold_pulses: got %0d want 5", pulses); end
    vectors++; if (col !== 5'd12)    begin miscompares++; $display("FAIL hold_col: got %0d want 12", col); end
    vectors++; if (xpos !== 10'd504) begin miscompares++; $display("FAIL hold_xpos: got %0d want 504", xpos); end
  endtask

  task automatic test_edges;
    logic mv, mg;
    logic [4:0] exp_c, exp_r;
    logic [9:0] exp_x, exp_y;
    logic exp_mv;
    // right edge
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) begin
      do_tick(1'b1, 1'b0, 1'b0, 1'b0, mv, mg);
      do_tick(1'b0, 1'b0, 1'b0, 1'b0, mv, mg);
    end
    vectors++; if (col !== 5'd15)    begin miscompares++; $display("FAIL edge_r_pre_col: got %0d want 15", col); end
    vectors++; if (xpos !== 10'd594) begin miscompares++; $display("FAIL edge_r_pre_xpos: got %0d want 594", xpos); end
    do_tick(1'b1, 1'b0, 1'b0, 1'b0, mv, mg);
`ifdef CURSOR_WRAP_EN
    exp_c = 5'd0;  exp_x = 10'd144; exp_mv = 1'b1;
`else
    exp_c = 5'd15; exp_x = 10'd594; exp_mv = 1'b0;
`endif
    vectors++; if (col !== exp_c)  begin miscompares++; $display("FAIL edge_r_col: got %0d want %0d", col, exp_c); end
    vectors++; if (xpos !== exp_x) begin miscompares++; $display("FAIL edge_r_xpos: got %0d want %0d", xpos, exp_x); end
    vectors++; if (mv !== exp_mv)  begin miscompares++; $display("FAIL edge_r_moved: got %b want %b", mv, exp_mv); end
    // left edge
    do_reset(1'b0);
    for (int i = 0; i < 7; i++) begin
      do_tick(1'b0, 1'b1, 1'b0, 1'b0, mv, mg);
      do_tick(1'b0, 1'b0, 1'b0, 1'b0, mv, mg);
    end
    vectors++; if (col !== 5'd0)     begin miscompares++; $display("FAIL edge_l_pre_col: got %0d want 0", col); end
    vectors++; if (xpos !== 10'd144) begin miscompares++; $display("FAIL edge_l_pre_xpos: got %0d want 144", xpos); end
    do_tick(1'b0, 1'b1, 1'b0, 1'b0, mv, mg);
`ifdef CURSOR_WRAP_EN
    exp_c = 5'd15; exp_x = 10'd594; exp_mv = 1'b1;
`else
    exp_c = 5'd0;  exp_x = 10'd144; exp_mv = 1'b0;
`endif
    vectors++; if (col !== exp_c)  begin miscompares++; $display("FAIL edge_l_col: got %0d want %0d", col, exp_c); end
    vectors++; if (xpos !== exp_x) begin miscompares++; $display("FAIL edge_l_xpos: got %0d want %0d", xpos, exp_x); end
    vectors++; if (mv !== exp_mv)  begin miscompares++; $display("FAIL edge_l_moved: got %b want %b", mv, exp_mv); end
    // top edge
    do_reset(1'b0);
    for (int i = 0; i < 7; i++) begin
      do_tick(1'b0, 1'b0, 1'b1, 1'b0, mv, mg);
      do_tick(1'b0, 1'b0, 1'b0, 1'b0, mv, mg);
    end
    vectors++; if (row !== 5'd0)    begin miscompares++; $display("FAIL edge_u_pre_row: got %0d want 0", row); end
    vectors++; if (ypos !== 10'd35) begin miscompares++; $display("FAIL edge_u_pre_ypos: got %0d want 35", ypos); end
    do_tick(1'b0, 1'b0, 1'b1, 1'b0, mv, mg);
`ifdef CURSOR_WRAP_EN
    exp_r = 5'd15; exp_y = 10'd485; exp_mv = 1'b1;
`else
    exp_r = 5'd0;  exp_y = 10'd35;  exp_mv = 1'b0;
`endif
    vectors++; if (row !== exp_r)  begin miscompares++; $display("FAIL edge_u_row: got %0d want %0d", row, exp_r); end
    vectors++; if (ypos !== exp_y) begin miscompares++; $display("FAIL edge_u_ypos: got %0d want %0d", ypos, exp_y); end
    vectors++; if (mv !== exp_mv)  begin miscompares++; $display("FAIL edge_u_moved: got %b want %b", mv, exp_mv); end
  endtask

  task automatic test_priority;
    logic mv, mg;
    do_reset(1'b0);
    do_tick(1'b1, 1'b0, 1'b1, 1'b0, mv, mg);
    vectors++; if (col !== 5'd8) begin miscompares++; $display("FAIL prio_ru_col: got %0d want 8", col); end
    vectors++; if (row !== 5'd7) begin miscompares++; $display("FAIL prio_ru_row: got %0d want 7", row); end
    do_tick(1'b0, 1'b0, 1'b1, 1'b0, mv, mg);
    vectors++; if (row !== 5'd6)     begin miscompares++; $display("FAIL prio_u_row: got %0d want 6", row); end
    vectors++; if (ypos !== 10'd215) begin miscompares++; $display("FAIL prio_u_ypos: got %0d want 215", ypos); end
    vectors++; if (mv !== 1'b1)      begin miscompares++; $display("FAIL prio_u_moved: got %b want 1", mv); end
    do_tick(1'b0, 1'b1, 1'b1, 1'b1, mv, mg);
    vectors++; if (col !== 5'd7) begin miscompares++; $display("FAIL prio_lud_col: got %0d want 7", col); end
    vectors++; if (row !== 5'd6) begin miscompares++; $display("FAIL prio_lud_row: got %0d want 6", row); end
    do_tick(1'b0, 1'b0, 1'b0, 1'b1, mv, mg);
    vectors++; if (row !== 5'd7)     begin miscompares++; $display("FAIL prio_d_row: got %0d want 7", row); end
    vectors++; if (ypos !== 10'd245) begin miscompares++; $display("FAIL prio_d_ypos: got %0d want 245", ypos); end
  endtask

  task automatic test_reset_mid_repeat;
    logic mv, mg;
    do_reset(1'b0);
    for (int i = 0; i < 25; i++) do_tick(1'b1, 1'b0, 1'b0, 1'b0, mv, mg);
    vectors++; if (col !== 5'd9) begin miscompares++; $display("FAIL mid_pre_col: got %0d want 9", col); end
    do_reset(1'b1);
    vectors++; if (col !== 5'd7)     begin miscompares++; $display("FAIL mid_rst_col: got %0d want 7", col); end
    vectors++; if (xpos !== 10'd354) begin miscompares++; $display("FAIL mid_rst_xpos: got %0d want 354", xpos); end
    vectors++; if (moved !== 1'b0)   begin miscompares++; $display("FAIL mid_rst_moved: got %b want 0", moved); end
    @(posedge clk); #1;
    vectors++; if (moved !== 1'b0)   begin miscompares++; $display("FAIL mid_rst_moved2: got %b want 0", moved); end
    do_tick(1'b1, 1'b0, 1'b0, 1'b0, mv, mg);
    vectors++; if (col !== 5'd8) begin miscompares++; $display("FAIL mid_fresh_col: got %0d want 8", col); end
    vectors++; if (mv !== 1'b1)  begin miscompares++; $display("FAIL mid_fresh_moved: got %b want 1", mv); end
  endtask

  task automatic test_tick_low_freeze;
    logic [4:0] c0, r0;
    logic [9:0] x0;
    c0 = col; r0 = row; x0 = xpos;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      right = i[0]; left = i[1]; up = i[2]; down = ~i[0];
      @(posedge clk); #1;
      vectors++; if (moved !== 1'b0) begin miscompares++; $display("FAIL freeze_moved_%0d: got %b want 0", i, moved); end
    end
    right = 1'b0; left = 1'b0; up = 1'b0; down = 1'b0;
    vectors++; if (col !== c0)  begin miscompares++; $display("FAIL freeze_col: got %0d want %0d", col, c0); end
    vectors++; if (row !== r0)  begin miscompares++; $display("FAIL freeze_row: got %0d want %0d", row, r0); end
    vectors++; if (xpos !== x0) begin miscompares++; $display("FAIL freeze_xpos: got %0d want %0d", xpos, x0); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_hold_repeat();
    test_edges();
    test_priority();
    test_reset_mid_repeat();
    test_tick_low_freeze();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
